// File: rtl/usart_pkg.sv
// Shared encodings, state type and reset constants for the USART access scheduler.
package usart_pkg;

    localparam int unsigned CTRL_W = 6;
    localparam int unsigned BYTE_W = 8;

    // {Rec,Trans} command encodings
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_TX   = 2'b01;
    localparam logic [1:0] CMD_RX   = 2'b10;
    localparam logic [1:0] CMD_CFG  = 2'b11;

    localparam logic [CTRL_W-1:0] CTRL_RST = 6'b011001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_TX,
        ST_RX,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic none;
        logic rec;
        logic trans;
    } usart_cmd_t;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 (TX side) has priority out of reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    logic ptr;

    always_comb begin
        gnt_c = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !ptr)) begin
                gnt_c[0] = 1'b1;
            end else if (req[1]) begin
                gnt_c[1] = 1'b1;
            end
        end
    end

    // priority passes to the side that was not just served
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= 1'b0;
        end else if (gnt_c[0]) begin
            ptr <= 1'b1;
        end else if (gnt_c[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/usart_access_sched.sv
// Serialises configure/transmit/receive requests onto a single USART command port,
// holding each command for a fixed phase and inserting an idle gap after it.
module usart_access_sched
    import usart_pkg::*;
#(
    parameter int unsigned CFG_HOLD = 4,
    parameter int unsigned TX_HOLD  = 500,
    parameter int unsigned RX_HOLD  = 500,
    parameter int unsigned GAP      = 2
) (
    input  logic              CPU_Clk,
    input  logic              Reset,
    input  logic              cfg_req,
    input  logic [CTRL_W-1:0] cfg_data,
    output logic              cfg_ack,
    input  logic              tx_valid,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_ready,
    input  logic              rx_req,
    output logic              rx_ack,
    output logic              rx_valid,
    output logic [BYTE_W-1:0] rx_data,
    output logic              busy,
    output logic              usart_None,
    output logic              usart_Rec,
    output logic              usart_Trans,
    output logic [CTRL_W-1:0] usart_Control,
    output logic [BYTE_W-1:0] usart_Data_in,
    input  logic [BYTE_W-1:0] usart_Data_out
);

    localparam int unsigned CNT_W = $clog2(max4(CFG_HOLD, TX_HOLD, RX_HOLD, GAP) + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    usart_cmd_t        cmd_q, cmd_d;
    logic              ack_pend, arb_en;
    logic [1:0]        gnt_c;
    logic              cfg_ack_d, tx_ready_d, rx_ack_d, rx_valid_d, busy_d;
    logic [CTRL_W-1:0] control_d;
    logic [BYTE_W-1:0] data_in_d, rx_data_d;

    // an ack cycle is still IDLE; no fresh decision is made while it is shown
    assign ack_pend = cfg_ack | tx_ready | rx_ack;
    assign arb_en   = (state == ST_IDLE) && !ack_pend && !cfg_req;

    rr_arb2 u_arb (
        .clk   (CPU_Clk),
        .reset (Reset),
        .en    (arb_en),
        .req   ({rx_req, tx_valid}),
        .gnt_c (gnt_c)
    );

    // state, phase counter and all output registers
    always_ff @(posedge CPU_Clk) begin
        if (Reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            cmd_q         <= {1'b0, CMD_IDLE};
            cfg_ack       <= 1'b0;
            tx_ready      <= 1'b0;
            rx_ack        <= 1'b0;
            rx_valid      <= 1'b0;
            busy          <= 1'b0;
            usart_Control <= CTRL_RST;
            usart_Data_in <= '0;
            rx_data       <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            cmd_q         <= cmd_d;
            cfg_ack       <= cfg_ack_d;
            tx_ready      <= tx_ready_d;
            rx_ack        <= rx_ack_d;
            rx_valid      <= rx_valid_d;
            busy          <= busy_d;
            usart_Control <= control_d;
            usart_Data_in <= data_in_d;
            rx_data       <= rx_data_d;
        end
    end

    // next state: leave IDLE after the ack cycle, count phases down to zero
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (cfg_ack) begin
                    state_nxt = ST_CFG;
                    cnt_nxt   = CNT_W'(CFG_HOLD - 1);
                end else if (tx_ready) begin
                    state_nxt = ST_TX;
                    cnt_nxt   = CNT_W'(TX_HOLD - 1);
                end else if (rx_ack) begin
                    state_nxt = ST_RX;
                    cnt_nxt   = CNT_W'(RX_HOLD - 1);
                end
            end
            ST_CFG, ST_TX, ST_RX: begin
                if (cnt == '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = CNT_W'(GAP - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // register inputs: grants, data captures and the command for the next cycle
    always_comb begin
        cfg_ack_d  = 1'b0;
        tx_ready_d = gnt_c[0];
        rx_ack_d   = gnt_c[1];
        rx_valid_d = 1'b0;
        control_d  = usart_Control;
        data_in_d  = usart_Data_in;
        rx_data_d  = rx_data;
        cmd_d      = {1'b0, CMD_IDLE};
        busy_d     = (state_nxt != ST_IDLE);

        if ((state == ST_IDLE) && !ack_pend) cfg_ack_d = cfg_req;
        if (cfg_ack)  control_d = cfg_data;
        if (tx_ready) data_in_d = tx_data;
        if ((state == ST_RX) && (cnt == '0)) begin
            rx_data_d  = usart_Data_out;
            rx_valid_d = 1'b1;
        end

        unique case (state_nxt)
            ST_CFG:  cmd_d = {1'b1, CMD_CFG};
            ST_TX:   cmd_d = {1'b1, CMD_TX};
            ST_RX:   cmd_d = {1'b1, CMD_RX};
            default: cmd_d = {1'b0, CMD_IDLE};
        endcase
    end

    assign usart_None  = cmd_q.none;
    assign usart_Rec   = cmd_q.rec;
    assign usart_Trans = cmd_q.trans;

endmodule

// File: tb/tb_usart_access_sched.sv
// Randomized scoreboard bench for usart_access_sched with a cycle-level port-occupancy model.
module tb_usart_access_sched;

    localparam int CFG_HOLD = 4;
    localparam int TX_HOLD  = 8;
    localparam int RX_HOLD  = 8;
    localparam int GAP      = 2;
    localparam int TMO      = 400;

    localparam int K_NONE = 0;
    localparam int K_CFG  = 1;
    localparam int K_TX   = 2;
    localparam int K_RX   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_req = 1'b0;
    logic [5:0] cfg_data = '0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       rx_req = 1'b0;
    logic [7:0] usart_data_out = '0;
    logic       cfg_ack, tx_ready, rx_ack, rx_valid, busy;
    logic [7:0] rx_data;
    logic       usart_none, usart_rec, usart_trans;
    logic [5:0] usart_control;
    logic [7:0] usart_data_in;

    usart_access_sched #(
        .CFG_HOLD (CFG_HOLD),
        .TX_HOLD  (TX_HOLD),
        .RX_HOLD  (RX_HOLD),
        .GAP      (GAP)
    ) dut (
        .CPU_Clk        (clk),
        .Reset          (reset),
        .cfg_req        (cfg_req),
        .cfg_data       (cfg_data),
        .cfg_ack        (cfg_ack),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .rx_req         (rx_req),
        .rx_ack         (rx_ack),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .busy           (busy),
        .usart_None     (usart_none),
        .usart_Rec      (usart_rec),
        .usart_Trans    (usart_trans),
        .usart_Control  (usart_control),
        .usart_Data_in  (usart_data_in),
        .usart_Data_out (usart_data_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // expected payloads, pushed when a request is raised
    logic [5:0] cfg_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    // port occupancy model: ack cycle, HOLD cycles of command, GAP idle cycles, then idle
    int         m_kind = K_NONE;
    bit         m_ack_now = 1'b0;
    int         m_hold = 0;
    int         m_gap = 0;
    bit         m_rxv = 1'b0;
    int         m_last = K_RX;
    logic [5:0] m_ctrl = 6'b011001;
    logic [7:0] m_din = '0;
    int         rx_cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] code_of(input int k);
        case (k)
            K_CFG:   return 3'b111;
            K_TX:    return 3'b101;
            K_RX:    return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int hold_of(input int k);
        case (k)
            K_CFG:   return CFG_HOLD;
            K_TX:    return TX_HOLD;
            default: return RX_HOLD;
        endcase
    endfunction

    // monitor: compare this cycle, pop on DUT outputs, drive the usart byte, advance model
    always @(negedge clk) begin
        if (mon_en) begin
            int got_ack;
            int n_ack;
            got_ack = K_NONE;
            n_ack = 0;
            if (cfg_ack)  begin got_ack = K_CFG; n_ack++; end
            if (tx_ready) begin got_ack = K_TX;  n_ack++; end
            if (rx_ack)   begin got_ack = K_RX;  n_ack++; end
            if (n_ack > 1) got_ack = 9;

            chk("cmd", 32'({usart_none, usart_rec, usart_trans}),
                32'((m_hold > 0) ? code_of(m_kind) : 3'b000));
            chk("grant", 32'(got_ack), 32'(m_ack_now ? m_kind : K_NONE));
            chk("busy", 32'(busy), 32'((m_hold > 0) || (m_gap > 0)));
            chk("control", 32'(usart_control), 32'(m_ctrl));
            chk("data_in", 32'(usart_data_in), 32'(m_din));
            chk("rx_valid", 32'(rx_valid), 32'(m_rxv));

            if (rx_valid) begin
                chk("rx_pending", 32'(rx_q.size() > 0), 32'(1));
                if (rx_q.size() > 0) chk("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
            end
            if (cfg_ack && cfg_q.size() > 0) m_ctrl = cfg_q.pop_front();
            if (tx_ready && tx_q.size() > 0) m_din = tx_q.pop_front();

            // usart side: the real byte only on the last receive-hold cycle
            if ({usart_none, usart_rec, usart_trans} == 3'b110) rx_cyc++;
            else rx_cyc = 0;
            if (rx_cyc == RX_HOLD && rx_q.size() > 0) usart_data_out = rx_q[0];
            else usart_data_out = 8'($urandom);

            if (reset) begin
                m_kind = K_NONE; m_ack_now = 1'b0; m_hold = 0; m_gap = 0; m_rxv = 1'b0;
                m_last = K_RX; m_ctrl = 6'b011001; m_din = '0;
            end else if (m_ack_now) begin
                m_ack_now = 1'b0;
                m_hold = hold_of(m_kind);
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) begin
                    m_gap = GAP;
                    m_rxv = (m_kind == K_RX);
                end
            end else if (m_gap > 0) begin
                m_gap--;
                m_rxv = 1'b0;
            end else if (cfg_req) begin
                m_kind = K_CFG; m_ack_now = 1'b1;
            end else if (tx_valid || rx_req) begin
                if (tx_valid && rx_req) m_kind = (m_last == K_TX) ? K_RX : K_TX;
                else m_kind = tx_valid ? K_TX : K_RX;
                m_last = m_kind;
                m_ack_now = 1'b1;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_cfg(input logic [5:0] d);
        int n = 0;
        cfg_q.push_back(d);
        cfg_data = d;
        cfg_req = 1'b1;
        while (!cfg_ack && n < TMO) begin @(posedge clk); #1; n++; end
        chk("cfg_ack_arrives", 32'(cfg_ack), 32'(1));
        @(posedge clk); #1;
        cfg_req = 1'b0;
    endtask

    task automatic do_tx(input logic [7:0] d);
        int n = 0;
        tx_q.push_back(d);
        tx_data = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < TMO) begin @(posedge clk); #1; n++; end
        chk("tx_ready_arrives", 32'(tx_ready), 32'(1));
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic do_rx(input logic [7:0] d);
        int n = 0;
        rx_q.push_back(d);
        rx_req = 1'b1;
        while (!rx_ack && n < TMO) begin @(posedge clk); #1; n++; end
        chk("rx_ack_arrives", 32'(rx_ack), 32'(1));
        @(posedge clk); #1;
        rx_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        chk("reset_none", 32'(usart_none), 32'(0));
        chk("reset_control", 32'(usart_control), 32'(6'b011001));
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_data_in", 32'(usart_data_in), 32'(0));
        chk("reset_rx_data", 32'(rx_data), 32'(0));
        wait_cycles(2);

        // single operations of each kind
        do_cfg(6'b100110);
        wait_cycles(12);
        do_tx(8'hA5);
        wait_cycles(12);
        do_rx(8'h3C);
        wait_cycles(12);

        // reset in the middle of a transmit hold
        do_tx(8'h5A);
        wait_cycles(3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midtx_none", 32'(usart_none), 32'(0));
        chk("midtx_control", 32'(usart_control), 32'(6'b011001));
        chk("midtx_busy", 32'(busy), 32'(0));
        chk("midtx_tx_ready", 32'(tx_ready), 32'(0));
        wait_cycles(2);

        // transmit request raised while a receive is being held
        do_rx(8'hC3);
        wait_cycles(2);
        do_tx(8'h77);
        wait_cycles(14);

        // all three requesters at once
        fork
            do_cfg(6'b010101);
            begin do_tx(8'h11); do_tx(8'h22); end
            begin do_rx(8'h33); do_rx(8'h44); end
        join
        wait_cycles(14);

        // randomized concurrent traffic
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    wait_cycles(int'($urandom_range(10, 60)));
                    do_cfg(6'($urandom));
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    wait_cycles(int'($urandom_range(0, 8)));
                    do_tx(8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    wait_cycles(int'($urandom_range(0, 8)));
                    do_rx(8'($urandom));
                end
            end
        join
        wait_cycles(30);

        chk("cfg_q_drained", 32'(cfg_q.size()), 32'(0));
        chk("tx_q_drained", 32'(tx_q.size()), 32'(0));
        chk("rx_q_drained", 32'(rx_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
